avalon_wait_ram: RTL and testbench

- Parametrised Avalon-MM slave RAM model used by the CPU benches. Successor to the fixed-size, zero-latency test RAM.
- Adds configurable depth and base address, a programmable wait-state count, byte-enable writes, a word preload port and a swept memory clear.
- Adds protocol-error detection so benches can flag CPU bus misbehaviour.
- Sits between top_level_cpu (Avalon master) and the testbench stimulus.

---
 rtl/avalon_wait_ram_if.sv | 20 ++
 rtl/avalon_wait_ram.sv | 165 ++++++++++++++++
 tb/tb_avalon_wait_ram.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus bundle between a CPU master and the avalon_wait_ram slave.
interface avalon_wait_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with wait states, byte enables, preload port, swept clear
// and sticky protocol-error flag. Define RANDOM_WAIT_EN for LFSR-driven wait counts.
module avalon_wait_ram #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  avalon_wait_ram_if.slave  bus,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              clear_mem,
  output logic              clear_busy,
  output logic              protocol_err
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned CNT_W  = (ADDR_W > WAIT_W) ? ADDR_W : WAIT_W;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_write_q, is_write_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              wait_req;
  logic              bus_we, clr_we;

  logic [31:0]       mem [DEPTH];

  logic [31:0]       offset;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic              req_one, req_same, accept;
  logic [CNT_W-1:0]  accept_last, wait_last;

  assign offset   = bus.address - BASE_ADDR;
  assign in_range = (bus.address[1:0] == 2'b00) && ({32'd0, offset} < (64'd4 << ADDR_W));
  assign idx      = offset[ADDR_W+1:2];
  assign rd_word  = in_range ? mem[idx] : '0;
  assign req_one  = bus.read ^ bus.write;
  assign req_same = req_one && (bus.write == is_write_q);
  assign accept   = (state_q == IDLE) && !clear_mem && req_one;

`ifdef RANDOM_WAIT_EN
  logic [15:0]      lfsr_q;
  logic [CNT_W-1:0] wait_q;

  assign accept_last = CNT_W'(32'd1 + 32'(lfsr_q[2:0]) % WAIT_CYCLES);
  assign wait_last   = wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
      wait_q <= '0;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      wait_q <= accept_last;
    end
  end
`else
  assign accept_last = CNT_W'(WAIT_CYCLES);
  assign wait_last   = CNT_W'(WAIT_CYCLES);
`endif

  // The counter includes the IDLE acceptance cycle, so WAIT exits one count
  // early and a one-cycle wait goes straight to ACK.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_req   = 1'b0;
    bus_we     = 1'b0;
    clr_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        wait_req = req_one;
        if (clear_mem) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (accept) begin
          is_write_d = bus.write;
          if (accept_last == CNT_W'(1)) begin
            state_d = ACK;
            if (!bus.write) rdata_d = rd_word;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else if (bus.read && bus.write) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        wait_req = 1'b1;
        if (!req_same) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_q + 1'b1 == wait_last) begin
          state_d = ACK;
          if (!is_write_q) rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (is_write_q) begin
          if (in_range) bus_we = 1'b1;
          else          err_d  = 1'b1;
        end
      end
      CLEAR: begin
        wait_req = 1'b1;
        clr_we   = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Memory survives reset; load is last so it wins over bus write and sweep.
  always_ff @(posedge clk) begin
    if (bus_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) mem[idx][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
    if (clr_we)  mem[cnt_q[ADDR_W-1:0]] <= '0;
    if (load_en) mem[load_addr] <= load_data;
  end

  assign bus.waitrequest = wait_req;
  assign bus.readdata    = rdata_q;
  assign clear_busy      = (state_q == CLEAR);
  assign protocol_err    = err_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Scoreboarded random/directed bench for avalon_wait_ram against a word-array model.
module tb_avalon_wait_ram;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DEPTH       = 256;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam logic [31:0] BASE        = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        clear_mem;
  logic        clear_busy;
  logic        protocol_err;

  avalon_wait_ram_if bus();

  avalon_wait_ram #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .clear_mem    (clear_mem),
    .clear_busy   (clear_busy),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  logic        model_err;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_stalls(input string name, input int st, input int extra);
`ifdef RANDOM_WAIT_EN
    checks++;
    if (st < extra + 1 || st > extra + int'(WAIT_CYCLES)) begin
      errors++;
      $display("FAIL %s: got %0d stall cycles, allowed %0d..%0d", name, st, extra + 1, extra + int'(WAIT_CYCLES));
    end
`else
    chk(name, 32'(st), 32'(extra + int'(WAIT_CYCLES)));
`endif
  endtask

  // Monitor: every read ACK pops one expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.read === 1'b1 && bus.write === 1'b0 && bus.waitrequest === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got readdata %h with no read outstanding", bus.readdata);
        end else begin
          chk("readdata", bus.readdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr_of(input int unsigned i);
    return BASE + 32'(i * 4);
  endfunction

  function automatic bit addr_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && (off < 32'(4 * DEPTH));
  endfunction

  function automatic int unsigned addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[9:2]);
  endfunction

  task automatic wait_ack(input string name, output int st, output bit ok);
    st = 0;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (bus.waitrequest) st++;
      else ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ACK after %0d stall cycles, required ACK", name, st);
    end
  endtask

  task automatic preload(input int unsigned i, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = 8'(i);
    load_data = d;
    cyc();
    load_en   = 1'b0;
    model_mem[i] = d;
  endtask

  task automatic do_read(input logic [31:0] a, input int extra, input string name);
    int st;
    bit ok;
    exp_q.push_back(addr_in_range(a) ? model_mem[addr_idx(a)] : 32'h0);
    bus.address = a;
    bus.read    = 1'b1;
    bus.write   = 1'b0;
    wait_ack(name, st, ok);
    if (ok) chk_stalls(name, st, extra);
    cyc();
    bus.read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit collide, input logic [31:0] ld, input string name);
    int st;
    bit ok;
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    wait_ack(name, st, ok);
    if (ok) chk_stalls(name, st, 0);
    if (collide) begin
      load_en   = 1'b1;
      load_addr = 8'(addr_idx(a));
      load_data = ld;
    end
    cyc();
    bus.write = 1'b0;
    load_en   = 1'b0;
    if (addr_in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[addr_idx(a)][8*b +: 8] = d[8*b +: 8];
      if (collide) model_mem[addr_idx(a)] = ld;
    end else begin
      model_err = 1'b1;
    end
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #12 reset = 1'b0;
    model_err = 1'b0;
    cyc();
  endtask

  initial begin
    int busy;
    reset          = 1'b1;
    bus.address    = '0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    load_en        = 1'b0;
    load_addr      = '0;
    load_data      = '0;
    clear_mem      = 1'b0;
    model_err      = 1'b0;

    #22;
    chk("reset_waitrequest", 32'(bus.waitrequest), 32'd0);
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_protocol_err", 32'(protocol_err), 32'd0);
    chk("reset_clear_busy", 32'(clear_busy), 32'd0);
    reset = 1'b0;
    cyc();

    // Sweep length with no competing traffic
    clear_mem = 1'b1;
    cyc();
    clear_mem = 1'b0;
    busy = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (clear_busy) busy++;
      else break;
    end
    chk("clear_busy_cycles", 32'(busy), 32'd256);
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    cyc();

    preload(1, 32'h24040FF0);
    do_read(BASE + 32'h4, 0, "t1_stalls");

    preload(3, 32'h11223344);
    do_write(addr_of(3), 32'hDEADBEEF, 4'b0101, 1'b0, '0, "t2_wr_stalls");
    do_read(addr_of(3), 0, "t2_rd_stalls");

    do_read(BASE + 32'h400, 0, "oor_rd_stalls");
    chk("oor_read_no_err", 32'(protocol_err), 32'd0);
    do_read(BASE + 32'h6, 0, "misaligned_rd_stalls");
    chk("misaligned_read_no_err", 32'(protocol_err), 32'd0);

    do_write(addr_of(2), 32'h55555555, 4'hF, 1'b1, 32'hA5A5A5A5, "collide_wr_stalls");
    do_read(addr_of(2), 0, "collide_rd_stalls");
    do_write(addr_of(DEPTH - 1), 32'h0BADF00D, 4'hF, 1'b0, '0, "top_wr_stalls");
    do_read(addr_of(DEPTH - 1), 0, "top_rd_stalls");

    for (int n = 0; n < 150; n++) begin
      int unsigned op, i;
      op = $urandom_range(0, 9);
      i  = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, 15);
      if (op == 0)      preload(i, $urandom);
      else if (op < 5)  do_write(addr_of(i), $urandom, 4'($urandom_range(0, 15)), 1'b0, '0, "rnd_wr_stalls");
      else              do_read(addr_of(i), 0, "rnd_rd_stalls");
    end
    chk("random_phase_err", 32'(protocol_err), 32'(model_err));

    do_write(BASE + 32'h400, 32'h12345678, 4'hF, 1'b0, '0, "oor_wr_stalls");
    chk("oor_write_err", 32'(protocol_err), 32'(model_err));

    apply_reset();
    chk("err_cleared_by_reset", 32'(protocol_err), 32'd0);
    chk("readdata_cleared_by_reset", bus.readdata, 32'h0);

    // Read issued during a sweep stalls until it ends and returns zero
    for (int i = 0; i < 4; i++) preload(i, 32'h1000_0000 + 32'(i));
    clear_mem = 1'b1;
    cyc();
    clear_mem = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    do_read(addr_of(2), int'(DEPTH), "clear_rd_stalls");

    // Read dropped after one wait cycle
    bus.address = addr_of(1);
    bus.read    = 1'b1;
    cyc();
    bus.read = 1'b0;
    cyc();
    chk("dropped_read_err", 32'(protocol_err), 32'd1);

    apply_reset();
    preload(4, 32'h44444444);
    bus.address    = addr_of(4);
    bus.writedata  = 32'hFFFFFFFF;
    bus.byteenable = 4'hF;
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    #3;
    chk("rw_both_waitrequest", 32'(bus.waitrequest), 32'd0);
    cyc();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    cyc();
    chk("rw_both_err", 32'(protocol_err), 32'd1);
    do_read(addr_of(4), 0, "rw_both_rd_stalls");

    apply_reset();
    preload(5, 32'h12345678);
    do_read(addr_of(5), 0, "pre_reset_rd_stalls");
    bus.address    = addr_of(5);
    bus.writedata  = 32'hCAFEF00D;
    bus.byteenable = 4'hF;
    bus.write      = 1'b1;
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("midwait_reset_readdata", bus.readdata, 32'h0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("post_reset_waitrequest", 32'(bus.waitrequest), 32'd1);
    bus.write = 1'b0;
    model_err = 1'b0;
    cyc();
    chk("post_reset_err", 32'(protocol_err), 32'd0);
    do_read(addr_of(5), 0, "post_reset_rd_stalls");

    cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
